// File: rtl/uart_led_pkg.sv
// Shared constants and the receiver state encoding for uart_led_rx.
`timescale 1ns/1ps
package uart_led_pkg;

    localparam int CLKS_PER_BIT_DEF = 104;
    localparam int DATA_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } uart_led_state_e;

endpackage

// File: rtl/uart_led_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (UART idle level).
`timescale 1ns/1ps
module uart_led_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_led_rx.sv
// 8N1 UART receiver driving an LED bank; mid-bit sampling with a one-cycle data_valid strobe.
// Optional stop-bit framing check is enabled by defining UART_LED_FRAME_CHECK_EN.
`timescale 1ns/1ps
module uart_led_rx
    import uart_led_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic [2:0]           o_dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_STOP  = ST_STOP;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_LED_FRAME_CHECK_EN
    logic                 r_frame_err;
`endif

    uart_led_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
`ifdef UART_LED_FRAME_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt != HALF_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (!w_rx_s) begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
`ifdef UART_LED_FRAME_CHECK_EN
                        if (w_rx_s) begin
                            data_out    <= r_shift;
                            data_valid  <= 1'b1;
                            r_frame_err <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
`else
                        data_out   <= r_shift;
                        data_valid <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
`ifdef UART_LED_FRAME_CHECK_EN
                    // After a framing error, hold here until the line is released.
                    if (!r_frame_err || w_rx_s) begin
                        r_frame_err <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_led_rx.sv
// Self-checking bench for uart_led_rx: directed UART frames plus randomized frames vs a byte-level model.
`timescale 1ns/1ps
module tb_uart_led_rx;
    import uart_led_pkg::*;

    localparam int CPB = 104;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] model_last;

    logic [7:0] prev_out;
    logic       prev_valid;
    logic       prev_rst;

    uart_led_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    // Monitor: collects strobed bytes and checks strobe width / output stability
    initial begin
        prev_out   = 8'h00;
        prev_valid = 1'b0;
        prev_rst   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && prev_rst) begin
                if (data_out !== prev_out) begin
                    n_checks++;
                    if (data_valid !== 1'b1) begin
                        n_errors++;
                        $display("FAIL data_out_stable: changed %h -> %h with data_valid=%b, expected change only with data_valid=1",
                                 prev_out, data_out, data_valid);
                    end
                end
                if (data_valid === 1'b1) begin
                    n_checks++;
                    if (prev_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL valid_width: data_valid high %0d cycles in a row, expected 1", 2);
                    end
                    obs_q.push_back(data_out);
                end
            end
            prev_out   = data_out;
            prev_valid = data_valid;
            prev_rst   = rst;
        end
    end

    // Reference model: a frame yields its byte unless the framing check rejects a 0 stop bit
    function automatic bit frame_accepted(input bit stop_bit);
`ifdef UART_LED_FRAME_CHECK_EN
        return stop_bit;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit stop_bit);
        if (frame_accepted(stop_bit)) begin
            exp_q.push_back(d);
            model_last = d;
        end
    endtask

    // Driver tasks
    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_out !== 8'h00 || data_valid !== 1'b0 || o_dbg_state !== 3'(ST_IDLE)) begin
                n_errors++;
                $display("FAIL reset_state: data_out=%h valid=%b state=%0d, expected 00/0/%0d",
                         data_out, data_valid, o_dbg_state, ST_IDLE);
            end
        end
        rst = 1'b1;
        model_last = 8'h00;
        idle_cycles(2 * CPB);
    endtask

    task automatic test_ascii_one();
        logic [7:0] e, o;
        send_frame(8'h31, 1'b1);
        model_frame(8'h31, 1'b1);
        idle_cycles(CPB);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL ascii_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL ascii_byte: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (data_out !== 8'd49) begin
            n_errors++;
            $display("FAIL ascii_hold: data_out=%0d, expected 49", data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, o;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        model_frame(8'h55, 1'b1);
        model_frame(8'hAA, 1'b1);
        idle_cycles(CPB);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL b2b_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL b2b_byte: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (data_out !== model_last) begin
            n_errors++;
            $display("FAIL b2b_hold: data_out=%h, expected %h", data_out, model_last);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle_cycles(2 * CPB);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL glitch_pulses: got %0d pulses, expected 0", obs_q.size());
        end
        obs_q.delete();
        n_checks++;
        if (data_out !== model_last || o_dbg_state !== 3'(ST_IDLE)) begin
            n_errors++;
            $display("FAIL glitch_hold: data_out=%h state=%0d, expected %h state=%0d",
                     data_out, o_dbg_state, model_last, ST_IDLE);
        end
    endtask

    task automatic test_framing_error();
        logic [7:0] e, o;
        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 1'b0);
        idle_cycles(2 * CPB);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL frame_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL frame_byte: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (data_out !== model_last) begin
            n_errors++;
            $display("FAIL frame_hold: data_out=%h, expected %h", data_out, model_last);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d, e, o;
        bit         stop_bit;
        for (int f = 0; f < 8; f++) begin
            d        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_bit);
            model_frame(d, stop_bit);
            if (!stop_bit)
                idle_cycles($urandom_range(CPB, 3 * CPB));
            else if ($urandom_range(0, 1) == 1)
                idle_cycles($urandom_range(1, 2 * CPB));
        end
        idle_cycles(CPB);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL random_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL random_byte: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (data_out !== model_last) begin
            n_errors++;
            $display("FAIL random_hold: data_out=%h, expected %h", data_out, model_last);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        logic [7:0] e, o;
        partial = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rx = partial[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        model_last = 8'h00;
        repeat (5) @(negedge clk);
        n_checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_clear: data_out=%h valid=%b, expected 00/0", data_out, data_valid);
        end
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(2 * CPB);
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1);
        idle_cycles(CPB);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL midreset_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL midreset_byte: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (data_out !== 8'h0F) begin
            n_errors++;
            $display("FAIL midreset_hold: data_out=%h, expected 0f", data_out);
        end
    endtask

    initial begin
        rst        = 1'b0;
        rx         = 1'b1;
        model_last = 8'h00;
        test_reset();
        test_ascii_one();
        test_glitch();
        test_back_to_back();
        test_framing_error();
        test_random_frames();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
